// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; data wins ties.
// Define MEM_ARB_FAIR_EN to compile in the starvation counter that forces an instruction grant.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_arbiter: STARVE_MAX must be within 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   dreq;
    logic   ireq;
    logic   starve_hit;

    assign dreq = dREN | dWEN;
    assign ireq = iREN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping the granted request aborts the access; ram_ready is then ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dreq && !starve_hit) begin
                    state_d = GRANT_D;
                end else if (ireq) begin
                    state_d = GRANT_I;
                end
            end
            GRANT_I: begin
                if (!iREN || ram_ready) begin
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                if (!dreq || ram_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            GRANT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            GRANT_D: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;
    assign iwait = iREN & ~((state_q == GRANT_I) & ram_ready);
    assign dwait = dreq & ~((state_q == GRANT_D) & ram_ready);

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] scnt_q, scnt_d;
    logic       i_done;
    logic       d_done;

    assign i_done = (state_q == GRANT_I) & iREN & ram_ready;
    assign d_done = (state_q == GRANT_D) & dreq & ram_ready;

    // Counts data completions that overtook a waiting fetch.
    always_comb begin
        scnt_d = scnt_q;
        if (!iREN || i_done) begin
            scnt_d = '0;
        end else if (d_done && (scnt_q < STARVE_LIM)) begin
            scnt_d = scnt_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign starve_hit = ireq & (scnt_q == STARVE_LIM);
`else
    assign starve_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int SMAX = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic inputs_idle();
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h0BAD_F00D;
    endtask

    task automatic test_reset();
        nRST = 0;
        iREN = 1; dREN = 1; dWEN = 0; ram_ready = 1;
        iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ramload = 32'h1234_5678;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL reset_ramREN got %b want 0", ramREN); end
        n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_ramWEN got %b want 0", ramWEN); end
        n_checks++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_ramaddr got %h want 0", ramaddr); end
        n_checks++; if (ramstore !== 32'h0) begin n_fail++; $display("FAIL reset_ramstore got %h want 0", ramstore); end
        n_checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL reset_waits got %b%b want 11", iwait, dwait); end
        n_checks++; if (iload !== 32'h1234_5678 || dload !== 32'h1234_5678) begin n_fail++; $display("FAIL reset_load got %h/%h want 12345678", iload, dload); end
        inputs_idle();
        #1;
        n_checks++; if (iwait !== 1'b0 || dwait !== 1'b0) begin n_fail++; $display("FAIL reset_waits_idle got %b%b want 00", iwait, dwait); end
        tick();
        nRST = 1;
        tick();
    endtask

    task automatic test_single_fetch();
        iREN = 1; iaddr = 32'h40;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL fetch_c1 got ren=%b iwait=%b want 0/1", ramREN, iwait); end
        tick(); @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin n_fail++; $display("FAIL fetch_c2 got ren=%b addr=%h iwait=%b want 1/40/1", ramREN, ramaddr, iwait); end
        tick(); ram_ready = 1; ramload = 32'h8C22_0004;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1 || iwait !== 1'b0 || iload !== 32'h8C22_0004) begin n_fail++; $display("FAIL fetch_c3 got ren=%b iwait=%b iload=%h want 1/0/8c220004", ramREN, iwait, iload); end
        tick(); ram_ready = 0;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL fetch_c4_idle got ren=%b iwait=%b want 0/1", ramREN, iwait); end
        tick(); iREN = 0;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0 || iwait !== 1'b0) begin n_fail++; $display("FAIL fetch_drop got ren=%b iwait=%b want 0/0", ramREN, iwait); end
        tick();
    endtask

    task automatic test_contention();
        nRST = 0;
        iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
        tick(); nRST = 1;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL cont_arb got ren=%b want 0", ramREN); end
        tick(); @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || iwait !== 1'b1) begin n_fail++; $display("FAIL cont_dfirst got ren=%b addr=%h iwait=%b want 1/300/1", ramREN, ramaddr, iwait); end
        tick(); ram_ready = 1;
        @(negedge CLK);
        n_checks++; if (dwait !== 1'b0 || iwait !== 1'b1 || ramaddr !== 32'h300) begin n_fail++; $display("FAIL cont_ddone got dwait=%b iwait=%b addr=%h want 0/1/300", dwait, iwait, ramaddr); end
        tick(); ram_ready = 0; dREN = 0;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL cont_gap got ren=%b iwait=%b want 0/1", ramREN, iwait); end
        tick(); ram_ready = 1;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 || iwait !== 1'b0) begin n_fail++; $display("FAIL cont_ithen got ren=%b addr=%h iwait=%b want 1/200/0", ramREN, ramaddr, iwait); end
        tick(); inputs_idle();
        tick();
    endtask

    task automatic test_write_precedence();
        dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        @(negedge CLK);
        n_checks++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin n_fail++; $display("FAIL wr_arb got wen=%b dwait=%b want 0/1", ramWEN, dwait); end
        tick(); @(negedge CLK);
        n_checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h100) begin n_fail++; $display("FAIL wr_drive got wen=%b ren=%b st=%h addr=%h want 1/0/deadbeef/100", ramWEN, ramREN, ramstore, ramaddr); end
        tick(); ram_ready = 1;
        @(negedge CLK);
        n_checks++; if (dwait !== 1'b0 || ramWEN !== 1'b1) begin n_fail++; $display("FAIL wr_done got dwait=%b wen=%b want 0/1", dwait, ramWEN); end
        tick(); inputs_idle();
        tick();
    endtask

    task automatic test_abort_reset();
        dREN = 1; daddr = 32'h500;
        tick(); @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_grant got ren=%b want 1", ramREN); end
        tick(); dREN = 0; ram_ready = 1;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b0) begin n_fail++; $display("FAIL abort_same got ren=%b wen=%b dwait=%b want 0/0/0", ramREN, ramWEN, dwait); end
        tick(); dREN = 1; ram_ready = 0;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL abort_idle got ren=%b want 0", ramREN); end
        tick(); @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_regrant got ren=%b want 1", ramREN); end
        tick(); dREN = 0;
        tick();
        // Data completion with a fetch waiting, then reset mid instruction grant.
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h600;
        tick(); ram_ready = 1;
        @(negedge CLK);
        n_checks++; if (ramaddr !== 32'h600 || dwait !== 1'b0) begin n_fail++; $display("FAIL rst_pre_d got addr=%h dwait=%b want 600/0", ramaddr, dwait); end
        tick(); dREN = 0; ram_ready = 0;
        tick(); @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin n_fail++; $display("FAIL rst_pre_i got ren=%b addr=%h want 1/44", ramREN, ramaddr); end
        #1 nRST = 0;
        #1;
        n_checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin n_fail++; $display("FAIL rst_mid got ren=%b addr=%h want 0/0", ramREN, ramaddr); end
`ifdef MEM_ARB_FAIR_EN
        n_checks++; if (dut.scnt_q !== 4'd0) begin n_fail++; $display("FAIL rst_scnt got %0d want 0", dut.scnt_q); end
`endif
        tick(); nRST = 1;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL rst_after_idle got ren=%b want 0", ramREN); end
        tick(); ram_ready = 1;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1 || iwait !== 1'b0) begin n_fail++; $display("FAIL rst_after_i got ren=%b iwait=%b want 1/0", ramREN, iwait); end
        tick(); inputs_idle();
        tick();
    endtask

    task automatic test_starvation();
        int grants[$];
        int i_low = 0;
        int n_i = 0;
        dREN = 1; iREN = 1; daddr = 32'h1000; iaddr = 32'h2000; ram_ready = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (ramREN || ramWEN) grants.push_back((ramaddr == 32'h2000) ? 1 : 0);
            if (!iwait) i_low++;
            tick();
        end
        inputs_idle();
        n_checks++; if (grants.size() < 15) begin n_fail++; $display("FAIL starve_count got %0d grants want >=15", grants.size()); end
        for (int k = 0; k < grants.size(); k++) begin
            int exp_g;
            exp_g = (FAIR && ((k % (SMAX + 1)) == SMAX)) ? 1 : 0;
            n_i += exp_g;
            n_checks++; if (grants[k] != exp_g) begin n_fail++; $display("FAIL starve_grant[%0d] got %0d want %0d (1=instr)", k, grants[k], exp_g); end
        end
        n_checks++; if (i_low != n_i) begin n_fail++; $display("FAIL starve_iwait_low got %0d cycles want %0d", i_low, n_i); end
        tick();
        tick();
    endtask

    task automatic test_random(input int ncyc);
        int own = 0;  // 0 none, 1 instruction, 2 data
        int sc = 0;
        int kind = 0;
        bit i_act = 0;
        bit d_act = 0;
        logic e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (!i_act && $urandom_range(0, 1) == 1) begin i_act = 1; iaddr = $urandom; end
            if (!d_act && $urandom_range(0, 2) != 0) begin
                d_act = 1; daddr = $urandom; dstore = $urandom; kind = $urandom_range(0, 2);
            end
            iREN = i_act;
            dREN = d_act && (kind != 1);
            dWEN = d_act && (kind != 0);
            ram_ready = ($urandom_range(0, 2) == 0);
            ramload = $urandom;
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
            if (own == 1) begin
                e_ren = 1; e_addr = iaddr;
            end else if (own == 2) begin
                e_ren = (kind == 0); e_wen = (kind != 0); e_addr = daddr; e_store = dstore;
            end
            e_iw = i_act && !(own == 1 && ram_ready);
            e_dw = d_act && !(own == 2 && ram_ready);
            @(negedge CLK);
            n_checks++;
            if (ramREN !== e_ren || ramWEN !== e_wen || ramaddr !== e_addr || ramstore !== e_store) begin
                n_fail++;
                $display("FAIL rand_ram c=%0d got ren=%b wen=%b addr=%h st=%h want %b/%b/%h/%h", c, ramREN, ramWEN, ramaddr, ramstore, e_ren, e_wen, e_addr, e_store);
            end
            n_checks++;
            if (iwait !== e_iw || dwait !== e_dw) begin
                n_fail++; $display("FAIL rand_wait c=%0d got i=%b d=%b want %b/%b", c, iwait, dwait, e_iw, e_dw);
            end
            n_checks++;
            if (iload !== ramload || dload !== ramload) begin
                n_fail++; $display("FAIL rand_load c=%0d got %h/%h want %h", c, iload, dload, ramload);
            end
            if (own == 0) begin
                if (d_act && !(FAIR && i_act && sc == SMAX)) own = 2;
                else if (i_act) own = 1;
            end else if (ram_ready) begin
                if (own == 2 && i_act && sc < SMAX) sc++;
                if (own == 1) sc = 0;
                own = 0;
            end
            if (!i_act) sc = 0;
            if (i_act && !e_iw) i_act = 0;
            if (d_act && !e_dw) d_act = 0;
        end
        tick();
        inputs_idle();
        tick();
    endtask

    initial begin
        inputs_idle();
        test_reset();
        test_single_fetch();
        test_contention();
        test_write_precedence();
        test_abort_reset();
        test_starvation();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
